// File: rtl/fir_coef_loader_pkg.sv
// Shared definitions for the FIR coefficient loader: controller state encoding.
package fir_coef_loader_pkg;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_LOAD  = 2'b01;
    localparam logic [1:0] S_FLUSH = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_LOAD  = S_LOAD,
        ST_FLUSH = S_FLUSH
    } state_e;

endpackage

// File: rtl/fir_coef_loader_if.sv
// Host-side and tap-chain-side signals of the coefficient loader, grouped as one bundle.
interface fir_coef_loader_if #(
    parameter int TW      = 16,
    parameter int LGNTAPS = 4
) ();

    logic               i_wr_stb;
    logic [LGNTAPS-1:0] i_wr_addr;
    logic [TW-1:0]      i_wr_data;
    logic               o_wr_err;
    logic               i_load_stb;
    logic               o_load_err;
    logic               o_busy;
    logic               o_coef_ok;
    logic               o_tap_wr;
    logic [TW-1:0]      o_tap;
    logic               i_ce;
    logic               o_ce;
    logic               o_valid;

    modport master (
        output i_wr_stb, i_wr_addr, i_wr_data, i_load_stb, i_ce,
        input  o_wr_err, o_load_err, o_busy, o_coef_ok, o_tap_wr, o_tap, o_ce, o_valid
    );

    modport slave (
        input  i_wr_stb, i_wr_addr, i_wr_data, i_load_stb, i_ce,
        output o_wr_err, o_load_err, o_busy, o_coef_ok, o_tap_wr, o_tap, o_ce, o_valid
    );

endinterface

// File: rtl/fir_coef_loader_ram.sv
// Coefficient staging RAM: NTAPS x TW, one write port, one registered read port.
// The array itself has no reset; only the read register is cleared so o_tap starts at zero.
module fir_coef_ram #(
    parameter int TW    = 16,
    parameter int NTAPS = 16,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [TW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [TW-1:0] o_rdata
);

    logic [TW-1:0] mem_q [NTAPS];
    logic [TW-1:0] rdata_q;

    // Storage write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Registered read port
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/fir_coef_loader.sv
// Sequences staged coefficients into the FIR tap chain, gating the sample
// enable while shifting and masking output-valid until the pipeline has flushed.
module fir_coef_loader
    import fir_coef_loader_pkg::*;
#(
    parameter int TW        = 16,
    parameter int LGNTAPS   = 4,
    parameter int NTAPS     = 16,
    parameter int FLUSH_LEN = 2 * NTAPS + 2
) (
    input logic               i_clk,
    input logic               i_reset_n,
    fir_coef_loader_if.slave  bus
);

    localparam int AW  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int LCW = $clog2(NTAPS + 1);
    localparam int FCW = $clog2(FLUSH_LEN + 2);
    localparam logic [LGNTAPS:0] NTAPS_A = (LGNTAPS + 1)'(NTAPS);
    localparam logic [LCW-1:0]   NTAPS_L = LCW'(NTAPS);
    localparam logic [FCW-1:0]   FLUSH_W = FCW'(FLUSH_LEN);

    state_e         state_q;
    logic [AW-1:0]  rd_addr_q;
    logic [LCW-1:0] ld_cnt_q;
    logic [FCW-1:0] flush_cnt_q;
    logic [FCW-1:0] flush_cnt_d;
    logic           wr_err_q;
    logic           load_err_q;
    logic           busy_q;
    logic           coef_ok_q;
    logic           tap_wr_q;
    logic           addr_ok_s;
    logic           wr_ok_s;
    logic           rd_en_s;
    logic           flush_done_s;

    assign addr_ok_s = ({1'b0, bus.i_wr_addr} < NTAPS_A);
    assign wr_ok_s   = bus.i_wr_stb && addr_ok_s && (state_q != ST_LOAD);
    assign rd_en_s   = (state_q == ST_LOAD);

    // Flush progress including the sample (if any) accepted this cycle
    always_comb begin
        flush_cnt_d  = flush_cnt_q + (bus.i_ce ? FCW'(1) : FCW'(0));
        flush_done_s = (flush_cnt_d >= FLUSH_W);
    end

    fir_coef_ram #(
        .TW    (TW),
        .NTAPS (NTAPS),
        .AW    (AW)
    ) u_ram (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_we      (wr_ok_s),
        .i_waddr   (bus.i_wr_addr[AW-1:0]),
        .i_wdata   (bus.i_wr_data),
        .i_re      (rd_en_s),
        .i_raddr   (rd_addr_q),
        .o_rdata   (bus.o_tap)
    );

    // Controller FSM with registered status and strobe outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            ld_cnt_q    <= '0;
            flush_cnt_q <= '0;
            wr_err_q    <= 1'b0;
            load_err_q  <= 1'b0;
            busy_q      <= 1'b0;
            coef_ok_q   <= 1'b0;
            tap_wr_q    <= 1'b0;
        end else begin
            wr_err_q   <= bus.i_wr_stb && !wr_ok_s;
            load_err_q <= bus.i_load_stb && (state_q == ST_LOAD);
            case (state_q)
                ST_IDLE: begin
                    tap_wr_q <= 1'b0;
                    if (bus.i_load_stb) begin
                        state_q   <= ST_LOAD;
                        busy_q    <= 1'b1;
                        coef_ok_q <= 1'b0;
                        rd_addr_q <= AW'(NTAPS - 1);
                        ld_cnt_q  <= '0;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // First cycle only primes the RAM read; shifts follow for NTAPS cycles
                    ld_cnt_q <= ld_cnt_q + LCW'(1);
                    if (rd_addr_q != '0) begin
                        rd_addr_q <= rd_addr_q - AW'(1);
                    end
                    if (ld_cnt_q < NTAPS_L) begin
                        tap_wr_q <= 1'b1;
                    end else begin
                        tap_wr_q    <= 1'b0;
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= '0;
                    end
                end
                ST_FLUSH: begin
                    tap_wr_q <= 1'b0;
                    if (bus.i_load_stb) begin
                        state_q     <= ST_LOAD;
                        rd_addr_q   <= AW'(NTAPS - 1);
                        ld_cnt_q    <= '0;
                        flush_cnt_q <= '0;
                    end else if (flush_done_s) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        coef_ok_q   <= 1'b1;
                        flush_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_d;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    coef_ok_q <= 1'b0;
                    tap_wr_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_wr_err   = wr_err_q;
    assign bus.o_load_err = load_err_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_coef_ok  = coef_ok_q;
    assign bus.o_tap_wr   = tap_wr_q;
    assign bus.o_ce       = bus.i_ce && (state_q != ST_LOAD);
    assign bus.o_valid    = bus.i_ce && (state_q == ST_IDLE) && coef_ok_q;

endmodule
